dbg_halt_ctrl: RTL

//  Debug halt/resume sequencer sitting directly upstream of the CSR debug-mode register.

---
 rtl/dbg_halt_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dbg_halt_ctrl.sv
// dbg_halt_ctrl
//   Debug halt/resume sequencer feeding the CSR debug-mode register. Collects
//   halt sources (haltreq, ebreak, single-step), waits for an instruction
//   boundary when needed, and issues a one-cycle write strobe with the new
//   debug-mode value. Tracks halted state, DCSR cause, the resume handshake
//   and a sticky halt-timeout error.
//
// Ports
//   clk             clock, rising edge
//   rst_i           asynchronous active-high reset
//   haltreq_i       level halt request
//   resumereq_i     level resume request
//   ebreak_i        ebreak executed (qualified by instr_retire_i)
//   step_i          dcsr.step
//   instr_retire_i  one instruction retired this cycle
//   boundary_i      core at a clean instruction boundary
//   clear_err_i     clears timeout_o
//   debug_req_o     1-cycle write strobe to the debug-mode register
//   debug_mode_d_o  value written when debug_req_o=1 (holds otherwise)
//   halted_o        core is in debug mode
//   resumeack_o     1-cycle resume-complete pulse
//   cause_o         DCSR cause of last halt: 1 ebreak, 3 haltreq, 4 step
//   timeout_o       sticky: halt not reached within HALT_TIMEOUT cycles
//
// state      | meaning
// S_RUN      | core running, watching halt sources
// S_WAIT_BND | halt pending, waiting for instruction boundary
// S_HALT_ENTER | strobe debug_mode=1 (one cycle)
// S_HALTED   | core in debug mode, waiting for resumereq
// S_RESUMING | strobe debug_mode=0 and ack (one cycle)
module dbg_halt_ctrl #(
  parameter int HALT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       haltreq_i,
  input  logic       resumereq_i,
  input  logic       ebreak_i,
  input  logic       step_i,
  input  logic       instr_retire_i,
  input  logic       boundary_i,
  input  logic       clear_err_i,
  output logic       debug_req_o,
  output logic       debug_mode_d_o,
  output logic       halted_o,
  output logic       resumeack_o,
  output logic [2:0] cause_o,
  output logic       timeout_o
);

  localparam int CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RUN, S_WAIT_BND, S_HALT_ENTER, S_HALTED, S_RESUMING
  } state_t;

  state_t           state_q, state_d;
  logic             step_pend_q, step_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cause_q, cause_d;
  logic             timeout_q, timeout_d;
  logic             req_q, req_d;
  logic             mode_q, mode_d;
  logic             halted_q, halted_d;
  logic             ack_q, ack_d;

  always_comb begin
    state_d     = state_q;
    step_pend_d = step_pend_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    // Clear first so a timeout event below in the same cycle wins.
    timeout_d   = timeout_q & ~clear_err_i;
    req_d       = 1'b0;
    mode_d      = mode_q;
    halted_d    = halted_q;
    ack_d       = 1'b0;

    case (state_q)
      S_RUN: begin
        if (instr_retire_i && step_i && !ebreak_i) step_pend_d = 1'b1;
        if (instr_retire_i && ebreak_i) begin
          state_d = S_HALT_ENTER;
          cause_d = 3'd1;
        end else if (haltreq_i || step_pend_q) begin
          state_d = S_WAIT_BND;
          cause_d = haltreq_i ? 3'd3 : 3'd4;
        end
      end
      S_WAIT_BND: begin
        if (instr_retire_i && ebreak_i) cause_d = 3'd1;
        if (boundary_i) begin
          state_d = S_HALT_ENTER;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) timeout_d = 1'b1;
        end
      end
      S_HALT_ENTER: begin
        halted_d    = 1'b1;
        step_pend_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_HALTED;
      end
      S_HALTED: begin
        if (resumereq_i) state_d = S_RESUMING;
      end
      S_RESUMING: begin
        halted_d = 1'b0;
        state_d  = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // Strobes are registered off the next state so they line up with the
    // one-cycle HALT_ENTER / RESUMING states.
    if (state_d == S_HALT_ENTER) begin
      req_d  = 1'b1;
      mode_d = 1'b1;
    end else if (state_d == S_RESUMING) begin
      req_d  = 1'b1;
      mode_d = 1'b0;
      ack_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      step_pend_q <= 1'b0;
      cnt_q       <= '0;
      cause_q     <= 3'd0;
      timeout_q   <= 1'b0;
      req_q       <= 1'b0;
      mode_q      <= 1'b0;
      halted_q    <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      timeout_q   <= timeout_d;
      req_q       <= req_d;
      mode_q      <= mode_d;
      halted_q    <= halted_d;
      ack_q       <= ack_d;
    end
  end

  assign debug_req_o    = req_q;
  assign debug_mode_d_o = mode_q;
  assign halted_o       = halted_q;
  assign resumeack_o    = ack_q;
  assign cause_o        = cause_q;
  assign timeout_o      = timeout_q;

endmodule
